i2c_master_tx: RTL and testbench
================================

# i2c_master_tx

Bit-level I2C write-only master that sits directly downstream of the `i2c_init` sequencer. It turns a start request plus a byte stream into START, N data bytes each followed by an ACK slot, then STOP, on push-pull SCL and open-drain SDA. It consumes one byte per `data_next` strobe, reports slave NACKs, and signals completion to the sequencer.

## Interface
- `CLK_DIV`, default 2: clk cycles per quarter bit period, ≥1; one bit = 4·CLK_DIV cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `packets`  in  3  byte count N (1..7), latched with `start`; 0 = request ignored.
- `data`  in  8  current byte, MSB sent first; latched when `data_next` is high.
- `sda_in`  in  1  sampled SDA line level, used for ACK.
- `data_next`  out  1  one-cycle strobe: `data` latched this cycle, upstream may advance to the next byte.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse after STOP completes.
- `ack_error`  out  1  set on NACK, cleared on the next accepted `start`.
- `scl`  out  1  I2C clock, driven push-pull, no clock stretching.
- `sda_pull`  out  1  1 = drive SDA low, 0 = release (line high via pull-up).

## Operation
- Reset values: `scl`=1, `sda_pull`=0, `busy`=0, `done`=0, `data_next`=0, `ack_error`=0, state IDLE.
- States: IDLE → START → DATA (8 bits) → ACK → (DATA for the next byte | STOP) → DONE → IDLE.
- A quarter counter (0..CLK_DIV-1) and a phase q0..q3 time every state except IDLE/DONE. Each START/DATA/ACK/STOP state lasts exactly 4 quarters.
- IDLE: `scl`=1, `sda_pull`=0.
  - `start`=1 and `packets`≠0: latch N and `data`, pulse `data_next`, clear `ack_error`, set byte counter to N, enter START.
- START: q0–q1 `scl`=1 with SDA released; q2–q3 `scl`=1 with `sda_pull`=1, so SDA falls while SCL is high.
- DATA bit k (k=7..0):
  - q0–q1: `scl`=0, `sda_pull` = ~shift[7].
  - q2–q3: `scl`=1, SDA held.
  - Shift left at the end of q3.
- ACK: `sda_pull`=0; `scl` sequenced as for DATA; `sda_in` sampled on the last cycle of q3.
  - `sda_in`=1 (NACK): set `ack_error`, go to STOP regardless of bytes remaining.
  - ACK and bytes remain: on that same last cycle, latch `data` into the shift register, pulse `data_next`, decrement the counter, go to DATA.
  - ACK and no bytes remain: go to STOP.
- STOP: q0–q2 `sda_pull`=1; q0–q1 `scl`=0; q2–q3 `scl`=1; q3 `sda_pull`=0, so SDA rises while SCL is high.
- DONE: one cycle, `done`=1, `busy`=0 → IDLE.
- `start` while not IDLE is ignored; it is not queued.
- `packets`/`data` changes mid-transaction have no effect except at `data_next` latch points.
- SDA changes only while `scl`=0, except for the START/STOP edges.
- Reset mid-transaction: next cycle all outputs are at reset values and the state is IDLE. No STOP is generated and `done` is not pulsed.

## Timing
- `start` sampled at edge T:
  - START begins at T+1.
  - `busy`=1 from T+1 through the last STOP cycle.
  - `done` at T+1+4·CLK_DIV·(2+9N).
- Byte b (0-based) `data_next` strobes:
  - b=0: at T.
  - b≥1: at T+4·CLK_DIV·(1+9b).
- Upstream must present byte b+1 before the next strobe. Combinational advance on the strobe edge is sufficient.
- NACK on byte b: STOP begins immediately after that ACK slot. `done` = T+1+4·CLK_DIV·(2+9(b+1)).
- A back-to-back `start` is accepted no earlier than the cycle after `done`.

## Test plan
- Reset → `scl`=1, `sda_pull`=0, `busy`/`done`/`data_next`/`ack_error`=0; hold 10 cycles with `start`=0 → no change.
- CLK_DIV=2, N=1, `data`=0xA5, `sda_in`=0:
  - SDA at each SCL rise reads 1,0,1,0,0,1,0,1 and then ACK.
  - Exactly one `data_next` strobe.
  - `done` 88 cycles after start-accept+1; `ack_error`=0.
- N=3, bytes 0xAB, 0xCD, 0xEF advanced on `data_next`, `sda_in`=0:
  - Three strobes, at T, T+80, T+152.
  - Serialized bits match all three bytes.
  - `done` at T+233.
- N=3, `sda_in`=1 during the first ACK slot:
  - `ack_error`=1, one strobe only, STOP follows immediately.
  - `done` at T+89.
  - `ack_error` clears on the next accepted `start`.
- `packets`=0 with `start` → stays IDLE. `start` pulsed mid-transaction → ignored and timing unchanged.
- Reset asserted during bit 4 of byte 1 → next cycle `scl`=1, `sda_pull`=0, `busy`=0, no `done`. A subsequent `start` runs a full transaction normally.

Source files
------------

// File: rtl/i2c_master_tx.sv
// Bit-level I2C write-only master: START, N bytes each followed by an ACK slot, STOP.
// SCL is push-pull; SDA is open-drain through sda_pull.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] packets,
  input  logic [7:0] data,
  input  logic       sda_in,
  output logic       data_next,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl,
  output logic       sda_pull
);

  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  bytes_q, bytes_d;
  logic [7:0]  shift_q, shift_d;
  logic        ack_error_q, ack_error_d;
  logic        scl_q, scl_d;
  logic        sda_pull_q, sda_pull_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic accept, timed, q_end, bit_end, more, load_next;

  assign accept    = (state_q == S_IDLE) && start && (packets != 3'd0);
  assign timed     = state_q inside {S_START, S_DATA, S_ACK, S_STOP};
  assign q_end     = (qcnt_q == QLAST);
  assign bit_end   = timed && q_end && (phase_q == 2'd3);
  assign more      = (bytes_q > 3'd1);
  assign load_next = (state_q == S_ACK) && bit_end && !sda_in && more;

  // Byte handshake is combinational so the latch and the strobe share one edge.
  assign data_next = (accept || load_next) && !reset;

  assign scl       = scl_q;
  assign sda_pull  = sda_pull_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;

  // State and datapath registers; line outputs registered from next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      phase_q     <= 2'd0;
      bit_q       <= 3'd7;
      bytes_q     <= 3'd0;
      shift_q     <= 8'd0;
      ack_error_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_pull_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      bytes_q     <= bytes_d;
      shift_q     <= shift_d;
      ack_error_q <= ack_error_d;
      scl_q       <= scl_d;
      sda_pull_q  <= sda_pull_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    bytes_d     = bytes_q;
    shift_d     = shift_q;
    ack_error_d = ack_error_q;

    if (timed) begin
      if (q_end) begin
        qcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        qcnt_d  = qcnt_q + QW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_START;
          shift_d     = data;
          bytes_d     = packets;
          bit_d       = 3'd7;
          ack_error_d = 1'b0;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q - 3'd1;
          if (bit_q == 3'd0) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (bit_end) begin
          if (sda_in) begin
            ack_error_d = 1'b1;
            state_d     = S_STOP;
          end else if (more) begin
            shift_d = data;
            bytes_d = bytes_q - 3'd1;
            state_d = S_DATA;
          end else begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: if (bit_end) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line and status levels for the coming cycle; SCL high in the second half of each bit.
  always_comb begin
    scl_d      = 1'b1;
    sda_pull_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      S_START: begin
        busy_d     = 1'b1;
        sda_pull_d = phase_d[1];
      end
      S_DATA: begin
        busy_d     = 1'b1;
        scl_d      = phase_d[1];
        sda_pull_d = ~shift_d[7];
      end
      S_ACK: begin
        busy_d = 1'b1;
        scl_d  = phase_d[1];
      end
      S_STOP: begin
        busy_d     = 1'b1;
        scl_d      = phase_d[1];
        sda_pull_d = (phase_d != 2'd3);
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx: serialized bits, strobe/done timing, NACK, ignored starts, reset abort.
module tb_i2c_master_tx;

  localparam int unsigned CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset, start, sda_in;
  logic [2:0] packets;
  logic [7:0] data;
  logic       data_next, busy, done, ack_error, scl, sda_pull;

  int total = 0;
  int bad   = 0;

  // Results of the last transaction run
  int          done_k, n_strobe, nrise, nhigh_edges, busy_bad;
  int          st [0:3];
  logic [63:0] rec;
  logic        ack_k1, ack_end;

  i2c_master_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .packets(packets), .data(data),
    .sda_in(sda_in), .data_next(data_next), .busy(busy), .done(done),
    .ack_error(ack_error), .scl(scl), .sda_pull(sda_pull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction, feeding the next byte after each strobe and recording the bus.
  task automatic run_txn(input logic [2:0] n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic sin, input int mid_k, input int abort_k);
    logic [7:0] bytes [3];
    int   nb;
    logic pend, pscl, psda;
    bytes = '{b0, b1, b2};
    done_k = -1; n_strobe = 0; nrise = 0; nhigh_edges = 0; busy_bad = 0;
    rec = '0; ack_k1 = 1'bx; ack_end = 1'bx;
    for (int i = 0; i < 4; i++) st[i] = -1;
    @(negedge clk);
    data = b0; packets = n; start = 1'b1; sda_in = sin;
    #1;
    pscl = scl; psda = sda_pull;
    if (data_next === 1'b1) begin st[0] = 0; n_strobe = 1; end
    pend = data_next;
    nb = 1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (data_next === 1'b1) begin
        if (n_strobe < 4) st[n_strobe] = k;
        n_strobe++;
      end
      if (scl && !pscl) begin rec = {rec[62:0], ~sda_pull}; nrise++; end
      if (scl && pscl && (sda_pull != psda)) nhigh_edges++;
      if (k == 1) ack_k1 = ack_error;
      pscl = scl; psda = sda_pull;
      if (done === 1'b1) begin
        done_k = k; ack_end = ack_error;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (k == 1) start = 1'b0;
      if (pend && nb < 3) begin data = bytes[nb]; nb++; end
      pend = data_next;
      if (k == mid_k) begin start = 1'b1; packets = 3'd3; end
      if (k == mid_k + 1) start = 1'b0;
      if (k == abort_k) begin reset = 1'b1; break; end
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; packets = 3'd0; data = 8'h00; sda_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_scl", 64'(scl), 64'd1);
    chk("rst_sda_pull", 64'(sda_pull), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data_next", 64'(data_next), 64'd0);
    chk("rst_ack_error", 64'(ack_error), 64'd0);

    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (scl !== 1'b1 || sda_pull !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          data_next !== 1'b0 || ack_error !== 1'b0) cnt++;
    end
    chk("idle_hold", 64'(cnt), 64'd0);

    // Single byte 0xA5 with ACK
    run_txn(3'd1, 8'hA5, 8'h00, 8'h00, 1'b0, 0, 0);
    chk("n1_done_k", 64'(done_k), 64'd89);
    chk("n1_strobes", 64'(n_strobe), 64'd1);
    chk("n1_strobe0", 64'(st[0]), 64'd0);
    chk("n1_rises", 64'(nrise), 64'd10);
    chk("n1_bits", rec, 64'({8'hA5, 1'b1, 1'b0}));
    chk("n1_start_stop_edges", 64'(nhigh_edges), 64'd2);
    chk("n1_busy", 64'(busy_bad), 64'd0);
    chk("n1_ack_error", 64'(ack_end), 64'd0);
    @(negedge clk);
    chk("n1_done_pulse", 64'({done, busy, scl, sda_pull}), 64'b0010);

    // Three bytes with ACK
    run_txn(3'd3, 8'hAB, 8'hCD, 8'hEF, 1'b0, 0, 0);
    chk("n3_done_k", 64'(done_k), 64'd233);
    chk("n3_strobes", 64'(n_strobe), 64'd3);
    chk("n3_strobe0", 64'(st[0]), 64'd0);
    chk("n3_strobe1", 64'(st[1]), 64'd80);
    chk("n3_strobe2", 64'(st[2]), 64'd152);
    chk("n3_rises", 64'(nrise), 64'd28);
    chk("n3_bits", rec, 64'({8'hAB, 1'b1, 8'hCD, 1'b1, 8'hEF, 1'b1, 1'b0}));
    chk("n3_start_stop_edges", 64'(nhigh_edges), 64'd2);
    chk("n3_busy", 64'(busy_bad), 64'd0);
    chk("n3_ack_error", 64'(ack_end), 64'd0);

    // NACK on first byte of three
    run_txn(3'd3, 8'h3C, 8'hCD, 8'hEF, 1'b1, 0, 0);
    chk("nack_done_k", 64'(done_k), 64'd89);
    chk("nack_strobes", 64'(n_strobe), 64'd1);
    chk("nack_ack_error", 64'(ack_end), 64'd1);
    chk("nack_bits", rec, 64'({8'h3C, 1'b1, 1'b0}));
    chk("nack_start_stop_edges", 64'(nhigh_edges), 64'd2);
    sda_in = 1'b0;

    // packets=0 request is ignored and leaves ack_error alone
    @(negedge clk);
    start = 1'b1; packets = 3'd0; data = 8'hFF;
    #1;
    chk("p0_data_next", 64'(data_next), 64'd0);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || scl !== 1'b1 || sda_pull !== 1'b0 || done !== 1'b0) cnt++;
    end
    chk("p0_idle", 64'(cnt), 64'd0);
    chk("p0_ack_error_kept", 64'(ack_error), 64'd1);

    // start pulsed mid-transaction is ignored; accepted start clears ack_error
    run_txn(3'd1, 8'h5A, 8'h00, 8'h00, 1'b0, 20, 0);
    chk("mid_ack_clr", 64'(ack_k1), 64'd0);
    chk("mid_done_k", 64'(done_k), 64'd89);
    chk("mid_strobes", 64'(n_strobe), 64'd1);
    chk("mid_bits", rec, 64'({8'h5A, 1'b1, 1'b0}));

    // Reset during bit 4 of byte 1
    run_txn(3'd3, 8'h11, 8'h96, 8'h22, 1'b0, 0, 106);
    chk("abort_strobes", 64'(n_strobe), 64'd2);
    @(negedge clk);
    chk("abort_lines", 64'({scl, sda_pull, busy, done, ack_error}), 64'b10000);
    reset = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("abort_quiet", 64'(cnt), 64'd0);

    // Full transaction after abort
    run_txn(3'd2, 8'hC3, 8'h81, 8'h00, 1'b0, 0, 0);
    chk("post_done_k", 64'(done_k), 64'd161);
    chk("post_strobes", 64'(n_strobe), 64'd2);
    chk("post_strobe1", 64'(st[1]), 64'd80);
    chk("post_rises", 64'(nrise), 64'd19);
    chk("post_bits", rec, 64'({8'hC3, 1'b1, 8'h81, 1'b1, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
